// File: rtl/scene_pixel_mux.sv
// Scene pixel mux: layer priority, scrolling floor texture, run/flash/over
// presentation FSM, and a two-stage pixel pipeline onto the VGA RGB bus.
//
// state     | meaning
// ----------+------------------------------------------------------------
// RUN       | game live; floor scrolls SCROLL_STEP px per frame
// HIT_FLASH | collision seen; goose blinks for FLASH_FRAMES frames
// OVER      | game over; dim sky, red goose, waits for restart
module scene_pixel_mux #(
    parameter int SCROLL_STEP  = 2,
    parameter int STRIPE_W     = 16,
    parameter int FLASH_FRAMES = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_tick,
    input  logic        video_on,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        frame_tick,
    input  logic        floor,
    input  logic        grass,
    input  logic        goose,
    input  logic        obstacle,
    input  logic        hit,
    input  logic        restart,
    output logic [11:0] rgb,
    output logic        game_over,
    output logic [9:0]  scroll_x
);

    localparam int          PAR_BIT    = $clog2(STRIPE_W);
    localparam logic [10:0] SCREEN_W   = 11'd640;
    localparam logic [10:0] STEP       = 11'(SCROLL_STEP);
    localparam logic [7:0]  FLASH_LOAD = 8'(FLASH_FRAMES);
    localparam logic [10:0] PAR_MASK   = 11'(1) << PAR_BIT;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_HIT_FLASH = 2'd1,
        ST_OVER      = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  scroll_q, scroll_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        phase_q, phase_d;
    logic        game_over_q, game_over_d;

    logic        s1_video_q, s1_floor_q, s1_grass_q, s1_goose_q, s1_obst_q, s1_par_q;
    logic [11:0] rgb_q, rgb_d;

    logic [10:0] tex_sum, tex_x, scroll_sum, scroll_wrap;
    logic        tex_par;

    // Row is not needed: region flags arrive already decoded per pixel.
    logic unused_y;
    assign unused_y = ^y;

    // Texture column: x plus scroll offset folded back into 0..639.
    always_comb begin
        tex_sum = {1'b0, x} + {1'b0, scroll_q};
        tex_x   = (tex_sum >= SCREEN_W) ? (tex_sum - SCREEN_W) : tex_sum;
        tex_par = |(tex_x & PAR_MASK);
    end

    // Next scroll offset with wrap at the screen width.
    always_comb begin
        scroll_sum  = {1'b0, scroll_q} + STEP;
        scroll_wrap = (scroll_sum >= SCREEN_W) ? (scroll_sum - SCREEN_W) : scroll_sum;
    end

    // FSM next-state: hit beats a coincident frame_tick in RUN.
    always_comb begin
        state_d  = state_q;
        scroll_d = scroll_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        case (state_q)
            ST_RUN: begin
                if (hit) begin
                    state_d = ST_HIT_FLASH;
                    cnt_d   = FLASH_LOAD;
                    phase_d = 1'b1;
                end else if (frame_tick) begin
                    scroll_d = 10'(scroll_wrap);
                end
            end
            ST_HIT_FLASH: begin
                if (frame_tick) begin
                    phase_d = ~phase_q;
                    cnt_d   = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) state_d = ST_OVER;
                end
            end
            ST_OVER: begin
                if (restart) begin
                    state_d  = ST_RUN;
                    scroll_d = 10'd0;
                    phase_d  = 1'b0;
                end
            end
            default: state_d = ST_RUN;
        endcase
        game_over_d = (state_d == ST_OVER);
    end

    // FSM state, scroll offset, flash counter/phase and game_over registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            scroll_q    <= 10'd0;
            cnt_q       <= 8'd0;
            phase_q     <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            scroll_q    <= scroll_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            game_over_q <= game_over_d;
        end
    end

    // Colour priority on stage-1 data, using the current presentation state.
    always_comb begin
        rgb_d = 12'h000;
        if (!s1_video_q) begin
            rgb_d = 12'h000;
        end else if (s1_goose_q) begin
            case (state_q)
                ST_HIT_FLASH: rgb_d = phase_q ? 12'hF00 : 12'hFFF;
                ST_OVER:      rgb_d = 12'hF00;
                default:      rgb_d = 12'hFFF;
            endcase
        end else if (s1_obst_q) begin
            rgb_d = 12'h333;
        end else if (s1_grass_q) begin
            rgb_d = 12'h2A2;
        end else if (s1_floor_q) begin
            rgb_d = s1_par_q ? 12'h963 : 12'h852;
        end else begin
            rgb_d = (state_q == ST_OVER) ? 12'h446 : 12'h8CF;
        end
    end

    // Two-stage pixel pipeline, advancing only on pixel enables.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_video_q <= 1'b0;
            s1_floor_q <= 1'b0;
            s1_grass_q <= 1'b0;
            s1_goose_q <= 1'b0;
            s1_obst_q  <= 1'b0;
            s1_par_q   <= 1'b0;
            rgb_q      <= 12'h000;
        end else if (p_tick) begin
            s1_video_q <= video_on;
            s1_floor_q <= floor;
            s1_grass_q <= grass;
            s1_goose_q <= goose;
            s1_obst_q  <= obstacle;
            s1_par_q   <= tex_par;
            rgb_q      <= rgb_d;
        end
    end

    assign rgb       = rgb_q;
    assign game_over = game_over_q;
    assign scroll_x  = scroll_q;

endmodule
